// File: rtl/page_walker_pkg.sv
// Shared definitions for the two-level page table walker.
package page_walker_pkg;

   localparam int unsigned ASID_WIDTH = 8;

   typedef logic [19:0] page_index_t;

   // Directory / table entry layout; superpage is meaningful in directory entries only.
   typedef struct packed {
      logic [19:0] ppn;
      logic [6:0]  rsvd;
      logic        superpage;
      logic        global;
      logic        supervisor;
      logic        exe_writable;
      logic        present;
   } pte_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      L1_REQ  = 3'd1,
      L1_WAIT = 3'd2,
      L2_REQ  = 3'd3,
      L2_WAIT = 3'd4,
      UPDATE  = 3'd5,
      FAULT   = 3'd6,
      DRAIN   = 3'd7
   } walker_state_t;

endpackage

// File: rtl/page_walker.sv
// Two-level page table walker: resolves a TLB miss via directory and table reads.
module page_walker
   import page_walker_pkg::*;
#(
   parameter bit SUPERPAGE_EN = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  miss_valid,
   output logic                  miss_ready,
   input  page_index_t           miss_vpage_idx,
   input  logic [ASID_WIDTH-1:0] miss_asid,
   input  logic [31:0]           page_dir_base,
   input  logic                  walk_abort,
   output logic                  mem_req_valid,
   output logic [31:0]           mem_req_addr,
   input  logic                  mem_req_ready,
   input  logic                  mem_resp_valid,
   input  logic [31:0]           mem_resp_data,
   output logic                  tlb_update_en,
   output page_index_t           tlb_update_vpage_idx,
   output logic [ASID_WIDTH-1:0] tlb_update_asid,
   output page_index_t           tlb_update_ppage_idx,
   output logic                  tlb_update_present,
   output logic                  tlb_update_exe_writable,
   output logic                  tlb_update_supervisor,
   output logic                  tlb_update_global,
   output logic                  walk_fault,
   output page_index_t           fault_vpage_idx,
   output logic                  fault_level
);

   walker_state_t         state_q, state_d;
   page_index_t           vpage_q, vpage_d;
   logic [ASID_WIDTH-1:0] asid_q, asid_d;
   logic [19:0]           base_q, base_d;
   logic [19:0]           table_q, table_d;
   page_index_t           ppage_q, ppage_d;
   logic [3:0]            flags_q, flags_d;   // {global, supervisor, exe_writable, present}
   logic                  level_q, level_d;
   pte_t                  pte;
   logic                  unused_bits;

   assign pte         = pte_t'(mem_resp_data);
   assign unused_bits = ^{page_dir_base[11:0], pte.rsvd};

   // State and walk-context registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         vpage_q <= '0;
         asid_q  <= '0;
         base_q  <= '0;
         table_q <= '0;
         ppage_q <= '0;
         flags_q <= '0;
         level_q <= 1'b0;
      end else begin
         state_q <= state_d;
         vpage_q <= vpage_d;
         asid_q  <= asid_d;
         base_q  <= base_d;
         table_q <= table_d;
         ppage_q <= ppage_d;
         flags_q <= flags_d;
         level_q <= level_d;
      end
   end

   // Next-state logic; abort takes priority over request handshake and response.
   always_comb begin
      state_d = state_q;
      vpage_d = vpage_q;
      asid_d  = asid_q;
      base_d  = base_q;
      table_d = table_q;
      ppage_d = ppage_q;
      flags_d = flags_q;
      level_d = level_q;
      case (state_q)
         IDLE: begin
            if (miss_valid) begin
               vpage_d = miss_vpage_idx;
               asid_d  = miss_asid;
               base_d  = page_dir_base[31:12];
               state_d = L1_REQ;
            end
         end
         L1_REQ: begin
            if (walk_abort)         state_d = IDLE;
            else if (mem_req_ready) state_d = L1_WAIT;
         end
         L1_WAIT: begin
            if (walk_abort) begin
               state_d = mem_resp_valid ? IDLE : DRAIN;
            end else if (mem_resp_valid) begin
               if (!pte.present) begin
                  level_d = 1'b0;
                  state_d = FAULT;
               end else if (SUPERPAGE_EN && pte.superpage) begin
                  ppage_d = {pte.ppn[19:10], vpage_q[9:0]};
                  flags_d = {pte.global, pte.supervisor, pte.exe_writable, 1'b1};
                  state_d = UPDATE;
               end else begin
                  table_d = pte.ppn;
                  state_d = L2_REQ;
               end
            end
         end
         L2_REQ: begin
            if (walk_abort)         state_d = IDLE;
            else if (mem_req_ready) state_d = L2_WAIT;
         end
         L2_WAIT: begin
            if (walk_abort) begin
               state_d = mem_resp_valid ? IDLE : DRAIN;
            end else if (mem_resp_valid) begin
               if (!pte.present) begin
                  level_d = 1'b1;
                  state_d = FAULT;
               end else begin
                  ppage_d = pte.ppn;
                  flags_d = {pte.global, pte.supervisor, pte.exe_writable, pte.present};
                  state_d = UPDATE;
               end
            end
         end
         UPDATE:  state_d = IDLE;
         FAULT:   state_d = IDLE;
         DRAIN: begin
            if (mem_resp_valid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output decode; everything is held at zero while reset is asserted.
   always_comb begin
      miss_ready              = 1'b0;
      mem_req_valid           = 1'b0;
      mem_req_addr            = '0;
      tlb_update_en           = 1'b0;
      tlb_update_vpage_idx    = '0;
      tlb_update_asid         = '0;
      tlb_update_ppage_idx    = '0;
      tlb_update_present      = 1'b0;
      tlb_update_exe_writable = 1'b0;
      tlb_update_supervisor   = 1'b0;
      tlb_update_global       = 1'b0;
      walk_fault              = 1'b0;
      fault_vpage_idx         = '0;
      fault_level             = 1'b0;
      if (!reset) begin
         case (state_q)
            IDLE: miss_ready = 1'b1;
            L1_REQ: begin
               mem_req_valid = !walk_abort;
               mem_req_addr  = {base_q, vpage_q[19:10], 2'b00};
            end
            L2_REQ: begin
               mem_req_valid = !walk_abort;
               mem_req_addr  = {table_q, vpage_q[9:0], 2'b00};
            end
            UPDATE: begin
               tlb_update_en           = 1'b1;
               tlb_update_vpage_idx    = vpage_q;
               tlb_update_asid         = asid_q;
               tlb_update_ppage_idx    = ppage_q;
               tlb_update_present      = flags_q[0];
               tlb_update_exe_writable = flags_q[1];
               tlb_update_supervisor   = flags_q[2];
               tlb_update_global       = flags_q[3];
            end
            FAULT: begin
               walk_fault      = 1'b1;
               fault_vpage_idx = vpage_q;
               fault_level     = level_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_page_walker.sv
// Directed self-checking bench for page_walker.
module tb_page_walker;
   import page_walker_pkg::*;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  miss_valid;
   logic                  miss_ready;
   page_index_t           miss_vpage_idx;
   logic [ASID_WIDTH-1:0] miss_asid;
   logic [31:0]           page_dir_base;
   logic                  walk_abort;
   logic                  mem_req_valid;
   logic [31:0]           mem_req_addr;
   logic                  mem_req_ready;
   logic                  mem_resp_valid;
   logic [31:0]           mem_resp_data;
   logic                  tlb_update_en;
   page_index_t           tlb_update_vpage_idx;
   logic [ASID_WIDTH-1:0] tlb_update_asid;
   page_index_t           tlb_update_ppage_idx;
   logic                  tlb_update_present;
   logic                  tlb_update_exe_writable;
   logic                  tlb_update_supervisor;
   logic                  tlb_update_global;
   logic                  walk_fault;
   page_index_t           fault_vpage_idx;
   logic                  fault_level;

   int n_cmp = 0;
   int n_bad = 0;

   page_walker #(.SUPERPAGE_EN(1'b1)) dut (
      .clk(clk), .reset(reset),
      .miss_valid(miss_valid), .miss_ready(miss_ready),
      .miss_vpage_idx(miss_vpage_idx), .miss_asid(miss_asid),
      .page_dir_base(page_dir_base), .walk_abort(walk_abort),
      .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
      .mem_req_ready(mem_req_ready),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .tlb_update_en(tlb_update_en), .tlb_update_vpage_idx(tlb_update_vpage_idx),
      .tlb_update_asid(tlb_update_asid), .tlb_update_ppage_idx(tlb_update_ppage_idx),
      .tlb_update_present(tlb_update_present),
      .tlb_update_exe_writable(tlb_update_exe_writable),
      .tlb_update_supervisor(tlb_update_supervisor),
      .tlb_update_global(tlb_update_global),
      .walk_fault(walk_fault), .fault_vpage_idx(fault_vpage_idx),
      .fault_level(fault_level)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic accept(input page_index_t vp);
      miss_valid     = 1'b1;
      miss_vpage_idx = vp;
      tick();
      miss_valid     = 1'b0;
   endtask

   task automatic respond(input logic [31:0] data);
      mem_resp_valid = 1'b1;
      mem_resp_data  = data;
      tick();
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_upd"}, {31'd0, tlb_update_en}, 32'd0);
      chk({tag, "_flt"}, {31'd0, walk_fault}, 32'd0);
   endtask

   initial begin
      reset = 1'b1; miss_valid = 1'b0; miss_vpage_idx = '0; miss_asid = 8'h5A;
      page_dir_base = 32'h0001_0000; walk_abort = 1'b0; mem_req_ready = 1'b1;
      mem_resp_valid = 1'b0; mem_resp_data = '0;

      // reset state
      tick(); tick();
      chk("rst_reqv", {31'd0, mem_req_valid}, 32'd0);
      chk("rst_addr", mem_req_addr, 32'd0);
      chk_quiet("rst");
      reset = 1'b0;
      #1;
      chk("rel_ready", {31'd0, miss_ready}, 32'd1);

      // base two-level walk, zero-wait memory
      accept(20'h12345);
      chk("b_l1v", {31'd0, mem_req_valid}, 32'd1);
      chk("b_l1a", mem_req_addr, 32'h0001_0120);
      chk("b_mrdy", {31'd0, miss_ready}, 32'd0);
      tick();
      chk("b_w1v", {31'd0, mem_req_valid}, 32'd0);
      respond(32'h0002_0001);
      chk("b_l2v", {31'd0, mem_req_valid}, 32'd1);
      chk("b_l2a", mem_req_addr, 32'h0002_0D14);
      chk_quiet("b_l2");
      tick();
      respond(32'h0ABC_D00B);
      chk("b_upd", {31'd0, tlb_update_en}, 32'd1);
      chk("b_vp", {12'd0, tlb_update_vpage_idx}, 32'h12345);
      chk("b_asid", {24'd0, tlb_update_asid}, 32'h5A);
      chk("b_pp", {12'd0, tlb_update_ppage_idx}, 32'h0ABCD);
      chk("b_flags", {28'd0, tlb_update_global, tlb_update_supervisor,
                      tlb_update_exe_writable, tlb_update_present}, 32'hB);
      tick();
      chk("b_done_upd", {31'd0, tlb_update_en}, 32'd0);
      chk("b_done_rdy", {31'd0, miss_ready}, 32'd1);

      // superpage terminates at the directory
      accept(20'h12345);
      chk("s_l1a", mem_req_addr, 32'h0001_0120);
      tick();
      respond(32'h0040_0011);
      chk("s_upd", {31'd0, tlb_update_en}, 32'd1);
      chk("s_reqv", {31'd0, mem_req_valid}, 32'd0);
      chk("s_pp", {12'd0, tlb_update_ppage_idx}, 32'h00745);
      chk("s_flags", {28'd0, tlb_update_global, tlb_update_supervisor,
                      tlb_update_exe_writable, tlb_update_present}, 32'h1);
      tick();

      // directory fault
      accept(20'h12345);
      tick();
      respond(32'h0002_0000);
      chk("d_flt", {31'd0, walk_fault}, 32'd1);
      chk("d_lvl", {31'd0, fault_level}, 32'd0);
      chk("d_vp", {12'd0, fault_vpage_idx}, 32'h12345);
      chk("d_upd", {31'd0, tlb_update_en}, 32'd0);
      tick();
      chk("d_rdy", {31'd0, miss_ready}, 32'd1);

      // table fault
      accept(20'h0ABCD);
      tick();
      respond(32'h0002_0001);
      tick();
      respond(32'h0ABC_D000);
      chk("t_flt", {31'd0, walk_fault}, 32'd1);
      chk("t_lvl", {31'd0, fault_level}, 32'd1);
      chk("t_vp", {12'd0, fault_vpage_idx}, 32'h0ABCD);
      tick();

      // back-pressure on the directory request
      mem_req_ready = 1'b0;
      accept(20'h12345);
      for (int i = 0; i < 3; i++) begin
         chk("bp_v", {31'd0, mem_req_valid}, 32'd1);
         chk("bp_a", mem_req_addr, 32'h0001_0120);
         chk("bp_rdy", {31'd0, miss_ready}, 32'd0);
         tick();
      end
      mem_req_ready = 1'b1;
      #1;
      chk("bp_hs_a", mem_req_addr, 32'h0001_0120);
      tick();
      mem_req_ready = 1'b0;
      chk("bp_once", {31'd0, mem_req_valid}, 32'd0);
      chk("bp_rdy2", {31'd0, miss_ready}, 32'd0);
      respond(32'h0002_0001);
      mem_req_ready = 1'b1;
      #1;
      chk("bp_l2a", mem_req_addr, 32'h0002_0D14);
      tick();
      respond(32'h0ABC_D00B);
      chk("bp_upd", {31'd0, tlb_update_en}, 32'd1);
      tick();

      // abort in L2_WAIT, response four cycles later is drained
      accept(20'h12345);
      tick();
      respond(32'h0002_0001);
      tick();
      walk_abort = 1'b1;
      tick();
      walk_abort = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("ab_rdy", {31'd0, miss_ready}, 32'd0);
         chk_quiet("ab");
         tick();
      end
      respond(32'h0ABC_D00B);
      chk("ab_idle", {31'd0, miss_ready}, 32'd1);
      chk_quiet("ab_end");

      // abort during a stalled request
      mem_req_ready = 1'b0;
      accept(20'h12345);
      walk_abort = 1'b1;
      #1;
      chk("ar_v", {31'd0, mem_req_valid}, 32'd0);
      tick();
      walk_abort = 1'b0;
      mem_req_ready = 1'b1;
      chk("ar_idle", {31'd0, miss_ready}, 32'd1);

      // abort coinciding with the response
      accept(20'h12345);
      tick();
      walk_abort = 1'b1;
      respond(32'h0002_0001);
      walk_abort = 1'b0;
      chk("ac_idle", {31'd0, miss_ready}, 32'd1);
      chk("ac_v", {31'd0, mem_req_valid}, 32'd0);

      // abort ignored in UPDATE
      accept(20'h12345);
      tick();
      respond(32'h0040_0011);
      walk_abort = 1'b1;
      #1;
      chk("au_upd", {31'd0, tlb_update_en}, 32'd1);
      tick();
      walk_abort = 1'b0;
      chk("au_idle", {31'd0, miss_ready}, 32'd1);

      // reset in L1_WAIT, late response ignored, then a clean walk
      accept(20'h12345);
      tick();
      reset = 1'b1;
      tick();
      chk("rw_v", {31'd0, mem_req_valid}, 32'd0);
      chk_quiet("rw");
      reset = 1'b0;
      respond(32'h0002_0001);
      chk("rw_rdy", {31'd0, miss_ready}, 32'd1);
      chk("rw_v2", {31'd0, mem_req_valid}, 32'd0);
      chk_quiet("rw_late");
      accept(20'h12345);
      chk("rw_l1a", mem_req_addr, 32'h0001_0120);
      tick();
      respond(32'h0002_0001);
      chk("rw_l2a", mem_req_addr, 32'h0002_0D14);
      tick();
      respond(32'h0ABC_D00B);
      chk("rw_upd", {31'd0, tlb_update_en}, 32'd1);
      chk("rw_pp", {12'd0, tlb_update_ppage_idx}, 32'h0ABCD);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
